branch_resolve_unit: RTL

//  Parametrised successor to the combinational branch comparator. Resolves branch/jump

---
 rtl/branch_resolve_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage with a one-entry registered result and a BHT of 2-bit counters.
// Optional performance counters are compiled in when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [2:0]      i_func3,
    input  logic [4:0]      i_opcode,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_lookup_taken,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic            o_taken,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    logic            r_out_valid;
    logic            r_taken;
    logic            r_mispredict;
    logic [XLEN-1:0] r_redirect_pc;
    logic [1:0]      r_bht [BHT_DEPTH];

    logic            w_accept;
    logic            w_is_branch;
    logic            w_is_jump;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_cf;
    logic            w_zf;
    logic            w_sf;
    logic            w_vf;
    logic            w_taken;
    logic            w_mispredict;
    logic [XLEN-1:0] w_redirect_pc;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [1:0]      w_bht_cur;
    logic [1:0]      w_bht_next;
    logic            w_lookup_unused;

    // Handshake: a transfer happens on a cycle where valid && ready are both high;
    // the producer holds its payload until then, and ready never depends on valid.
    assign o_in_ready = !r_out_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    assign w_is_branch = (i_opcode == OP_BRANCH);
    assign w_is_jump   = (i_opcode == OP_JAL) || (i_opcode == OP_JALR);

    // rs1 - rs2 as rs1 + ~rs2 + 1 so carry/overflow fall out of one adder.
    assign w_sum  = {1'b0, i_rs1} + {1'b0, ~i_rs2} + {{XLEN{1'b0}}, 1'b1};
    assign w_diff = w_sum[XLEN-1:0];
    assign w_cf   = w_sum[XLEN];
    assign w_zf   = (w_diff == '0);
    assign w_sf   = w_diff[XLEN-1];
    assign w_vf   = i_rs1[XLEN-1] ^ ~i_rs2[XLEN-1] ^ w_diff[XLEN-1] ^ w_cf;

    always_comb begin
        w_taken = 1'b0;
        if (w_is_jump) begin
            w_taken = 1'b1;
        end else if (w_is_branch) begin
            case (i_func3)
                3'b000:  w_taken = w_zf;
                3'b001:  w_taken = !w_zf;
                3'b100:  w_taken = (w_sf != w_vf);
                3'b101:  w_taken = (w_sf == w_vf);
                3'b110:  w_taken = !w_cf;
                3'b111:  w_taken = w_cf;
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_mispredict  = (w_is_branch || w_is_jump) && (w_taken != i_pred_taken);
    assign w_redirect_pc = w_taken ? i_target : (i_pc + XLEN'(4));

    assign w_idx        = i_pc[IDX_W+1:2];
    assign w_lookup_idx = i_lookup_pc[IDX_W+1:2];
    assign w_bht_cur    = r_bht[w_idx];

    always_comb begin
        w_bht_next = w_bht_cur;
        if (w_taken && w_bht_cur != 2'b11) begin
            w_bht_next = w_bht_cur + 2'b01;
        end else if (!w_taken && w_bht_cur != 2'b00) begin
            w_bht_next = w_bht_cur - 2'b01;
        end
    end

    // Reads see the array before this cycle's write lands.
    assign o_lookup_taken  = r_bht[w_lookup_idx][1];
    assign w_lookup_unused = ^{i_lookup_pc[XLEN-1:IDX_W+2], i_lookup_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_taken       <= w_taken;
                r_mispredict  <= w_mispredict;
                r_redirect_pc <= w_redirect_pc;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && w_is_branch) begin
            r_bht[w_idx] <= w_bht_next;
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_taken       = r_taken;
    assign o_mispredict  = r_mispredict;
    assign o_redirect_pc = r_redirect_pc;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            if (w_is_branch || w_is_jump) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`endif

endmodule
